// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one single-owner resource.
// The winner is found by masking off requesters below the priority pointer
// and taking the lowest set bit, falling back to the lowest set bit of the raw
// request vector. Grants are registered and held until the owner releases,
// the owner drops its request, or the hold limit expires.
module rr_arbiter #(
   parameter  int NUM_REQ  = 4,
   parameter  int MAX_HOLD = 16,
   localparam int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_release,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_gnt_idx,
   output logic               o_gnt_valid,
   output logic               o_timeout
);

   // Hold counter must be able to represent MAX_HOLD itself.
   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t               state_q,   state_d;
   logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic                 valid_q,   valid_d;
   logic                 timeout_q, timeout_d;
   logic [HOLD_W-1:0]    hold_q,    hold_d;
   logic [IDX_W-1:0]     ptr_q,     ptr_d;

   logic [NUM_REQ-1:0]   masked;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [IDX_W-1:0]     win_idx;
   logic                 any_req;
   logic                 any_masked;
   logic                 owner_req;
   logic                 hold_limit;
   logic                 hold_sat;

   // Index of the lowest set bit; zero when the vector is empty (callers
   // only use the result when at least one bit is set).
   function automatic logic [IDX_W-1:0] trailing_one(input logic [NUM_REQ-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (v[k]) begin
            r = IDX_W'(k);
         end
      end
      return r;
   endfunction

   // Per-requester mask against the pointer and one-hot decode of the
   // winner. Only real requester bits exist, so padding can never win.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         localparam logic [IDX_W-1:0] K = IDX_W'(gi);
         assign masked[gi]     = i_req[gi] & (K >= ptr_q);
         assign win_onehot[gi] = (win_idx == K);
      end
   endgenerate

   assign any_req    = |i_req;
   assign any_masked = |masked;
   assign win_idx    = any_masked ? trailing_one(masked) : trailing_one(i_req);

   // gnt_q is one-hot on the owner, so this is the owner's own request bit.
   assign owner_req  = |(i_req & gnt_q);

   assign hold_sat   = (hold_q == HOLD_W'(MAX_HOLD));
   assign hold_limit = (MAX_HOLD != 0) && hold_sat;

   // Next-state and registered-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      ptr_d     = ptr_q;

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_GRANT;
               gnt_d   = win_onehot;
               idx_d   = win_idx;
               valid_d = 1'b1;
               hold_d  = HOLD_W'(1);
               // Priority moves just past the winner, wrapping at the top.
               ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end
         end

         S_GRANT: begin
            if (i_release || !owner_req) begin
               // A release wins over a simultaneous hold-limit expiry.
               state_d = S_IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
               hold_d  = '0;
            end else if (hold_limit) begin
               state_d   = S_IDLE;
               gnt_d     = '0;
               valid_d   = 1'b0;
               hold_d    = '0;
               timeout_d = 1'b1;
            end else if ((MAX_HOLD != 0) && !hold_sat) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         ptr_q     <= ptr_d;
      end
   end

   assign o_gnt       = gnt_q;
   assign o_gnt_idx   = idx_q;
   assign o_gnt_valid = valid_q;
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural round-robin model.
module tb_rr_arbiter;

   localparam int N    = 4;
   localparam int MAXH = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         rel;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_idx;
   logic         gnt_valid;
   logic         timeout;

   int vectors;
   int miscompares;

   // Reference model state, kept as plain integers.
   bit m_grant;
   int m_owner;
   int m_hold;
   int m_ptr;
   bit m_timeout;

   rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_release   (rel),
      .o_gnt       (gnt),
      .o_gnt_idx   (gnt_idx),
      .o_gnt_valid (gnt_valid),
      .o_timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs the DUT sees.
   task automatic model_step(input logic r_n, input logic [N-1:0] rq, input logic rl);
      int w;
      if (!r_n) begin
         m_grant = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_timeout = 0;
      end else if (!m_grant) begin
         m_timeout = 0;
         if (rq != 0) begin
            // Search the requesters in circular order starting at the pointer.
            w = -1;
            for (int i = 0; i < N; i++) begin
               if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            end
            m_grant = 1;
            m_owner = w;
            m_hold  = 1;
            m_ptr   = (w + 1) % N;
         end
      end else begin
         m_timeout = 0;
         if (rl || !rq[m_owner]) begin
            m_grant = 0;
         end else if (m_hold == MAXH) begin
            m_grant   = 0;
            m_timeout = 1;
         end else begin
            m_hold++;
         end
      end
   endtask

   // One clock: drive, let the edge happen, then compare all outputs.
   task automatic cycle(input logic r_n, input logic [N-1:0] rq, input logic rl);
      logic [N-1:0] exp_gnt;
      rst_n = r_n;
      req   = rq;
      rel   = rl;
      @(posedge clk);
      model_step(r_n, rq, rl);
      #1;
      exp_gnt = '0;
      if (m_grant) exp_gnt[m_owner] = 1'b1;
      chk("gnt",     32'(gnt),       32'(exp_gnt));
      chk("gnt_idx", 32'(gnt_idx),   32'(m_owner));
      chk("valid",   32'(gnt_valid), 32'(m_grant));
      chk("timeout", 32'(timeout),   32'(m_timeout));
      $display("cyc rst_n=%0b req=%b rel=%0b -> gnt=%b idx=%0d valid=%0b to=%0b",
               r_n, rq, rl, gnt, gnt_idx, gnt_valid, timeout);
   endtask

   initial begin
      logic [N-1:0] rq;
      logic         rl;
      logic         rn;

      vectors     = 0;
      miscompares = 0;
      m_grant = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_timeout = 0;
      rst_n = 1'b0;
      req   = '0;
      rel   = 1'b0;

      // Reset for two cycles, then first grant.
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b1010, 1'b0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      cycle(1'b1, 4'b1010, 1'b0);
      chk("first_gnt", 32'(gnt), 32'b0010);
      chk("first_idx", 32'(gnt_idx), 32'd1);
      cycle(1'b1, 4'b1010, 1'b1);

      // Rotation from a fresh reset: expect 0,1,2,3,0.
      cycle(1'b0, 4'b0000, 1'b0);
      for (int g = 0; g < 5; g++) begin
         cycle(1'b1, 4'b1111, 1'b0);
         chk("rot_idx", 32'(gnt_idx), 32'(g % N));
         chk("rot_valid", 32'(gnt_valid), 32'd1);
         cycle(1'b1, 4'b1111, 1'b0);
         cycle(1'b1, 4'b1111, 1'b1);
         chk("rot_gap", 32'(gnt_valid), 32'd0);
      end

      // Wrap and skip: grant to 2 leaves ptr at 3, then 0011 gives 0 then 1.
      cycle(1'b1, 4'b0100, 1'b0);
      chk("wrap_g2", 32'(gnt_idx), 32'd2);
      cycle(1'b1, 4'b0100, 1'b1);
      cycle(1'b1, 4'b0011, 1'b0);
      chk("wrap_g0", 32'(gnt), 32'b0001);
      cycle(1'b1, 4'b0011, 1'b1);
      cycle(1'b1, 4'b0011, 1'b0);
      chk("wrap_g1", 32'(gnt), 32'b0010);
      cycle(1'b1, 4'b0011, 1'b1);

      // Timeout: valid for exactly MAXH cycles, pulse, then re-grant.
      for (int i = 0; i < MAXH; i++) begin
         cycle(1'b1, 4'b0001, 1'b0);
         chk("to_held", 32'(gnt_valid), 32'd1);
      end
      cycle(1'b1, 4'b0001, 1'b0);
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_drop", 32'(gnt_valid), 32'd0);
      cycle(1'b1, 4'b0001, 1'b0);
      chk("to_regrant", 32'(gnt), 32'b0001);
      chk("to_once", 32'(timeout), 32'd0);
      cycle(1'b1, 4'b0001, 1'b1);

      // Release on the last allowed grant cycle: no timeout pulse.
      for (int i = 0; i < MAXH; i++) cycle(1'b1, 4'b0001, 1'b0);
      cycle(1'b1, 4'b0001, 1'b1);
      chk("coll_to", 32'(timeout), 32'd0);
      chk("coll_valid", 32'(gnt_valid), 32'd0);

      // Reset during a grant to requester 2, then restart at requester 0.
      cycle(1'b1, 4'b0100, 1'b0);
      chk("mr_gnt", 32'(gnt), 32'b0100);
      cycle(1'b0, 4'b1111, 1'b0);
      chk("mr_clear", 32'(gnt), 32'h0);
      chk("mr_idx", 32'(gnt_idx), 32'd0);
      chk("mr_to", 32'(timeout), 32'd0);
      cycle(1'b1, 4'b1111, 1'b0);
      chk("mr_next", 32'(gnt), 32'b0001);

      // Randomized traffic; owners usually keep requesting to reach timeouts.
      for (int t = 0; t < 400; t++) begin
         rq = 4'($urandom_range(0, 15));
         if (m_grant && $urandom_range(0, 3) != 0) rq[m_owner] = 1'b1;
         rl = ($urandom_range(0, 7) == 0);
         rn = ($urandom_range(0, 63) != 0);
         cycle(rn, rq, rl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one single-owner resource (e.g., memory port, CSR bus, or multi-cycle execution unit) among `NUM_REQ` requesters. It picks the winner by rotating the request vector to the current priority pointer and finding the trailing one. Each grant is registered and held until the owner releases it or a hold limit expires. It sits between the requesting pipeline stages and the shared resource's input mux, and `o_gnt_idx` drives that mux select.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2, need not be a power of two.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before a forced revoke; 0 disables the limit.
- `IDX_W`, derived as `$clog2(NUM_REQ)`: width of the index outputs. Not overridable.
- The block has one clock. Reset is synchronous and active-low.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  synchronous active-low reset.
- `i_req`  in  `NUM_REQ`  level request per requester; bit k = requester k.
- `i_release`  in  1  owner finished; sampled only in GRANT.
- `o_gnt`  out  `NUM_REQ`  one-hot grant, registered; all-zero when not granting.
- `o_gnt_idx`  out  `IDX_W`  index of the current owner; holds the last owner when not granting.
- `o_gnt_valid`  out  1  high exactly when `o_gnt` is nonzero.
- `o_timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- FSM states are IDLE and GRANT.
- Reset values: state IDLE; `o_gnt` = 0; `o_gnt_valid` = 0; `o_gnt_idx` = 0; `o_timeout` = 0; hold counter = 0.
- Reset sets the priority pointer `ptr` to 0, so the first search starts at requester 0.
- Arbitration (IDLE with `|i_req`):
  - Compute `masked = i_req & (~0 << ptr)`.
  - If `masked` ≠ 0, the winner is the trailing-one index of `masked`. Otherwise it is the trailing-one index of `i_req`.
  - Unused padding bits, when `NUM_REQ` is not a power of two, are zero and never win.
- On a win: next state is GRANT; `o_gnt` = one-hot(winner); `o_gnt_idx` = winner; hold counter = 1.
- `ptr` ← winner+1, wrapping to 0 when winner = `NUM_REQ`-1.
- In IDLE with `i_req` = 0: stay in IDLE; `ptr` unchanged.
- In GRANT, any of these ends the grant (next state IDLE, `o_gnt` = 0, `o_gnt_valid` = 0):
  - (a) `i_release` = 1;
  - (b) `i_req[o_gnt_idx]` = 0 (the owner drops its request);
  - (c) `MAX_HOLD` ≠ 0 and hold counter == `MAX_HOLD`. In this case `o_timeout` = 1 for that IDLE cycle.
- If (a) or (b) occurs in the same cycle as (c), the grant ends as a release and `o_timeout` stays 0.
- Otherwise GRANT is held and the hold counter increments, saturating at `MAX_HOLD`.
- Requests from non-owners during GRANT are ignored. They are not latched, and they are evaluated fresh in the next IDLE cycle.
- `ptr` changes only on a win, so a timed-out owner loses priority to the others.
- Reset asserted mid-grant: the next edge forces all of the reset values above. No timeout pulse is generated.

## Timing
- Request to grant: 1 cycle. `i_req` high in IDLE at edge t gives `o_gnt` valid after edge t+1.
- Release to idle: 1 cycle. There is a mandatory one-cycle IDLE gap between consecutive grants.
- Minimum grant period is therefore 2 cycles: 1 GRANT + 1 IDLE.
- Grant duration is at most `MAX_HOLD` cycles. `o_gnt_valid` is high for exactly `MAX_HOLD` consecutive cycles before a forced revoke.
- All outputs are registered; there is no combinational path from input to output.
- Under continuous requests from all N requesters, each requester is granted at least once every N grants. This is the no-starvation guarantee.

## Test plan
- Reset/first grant: hold `i_rst_n`=0 for 2 cycles, then `i_req`=4'b1010. Expect `o_gnt`=4'b0010 and `o_gnt_idx`=1 one cycle later; all outputs 0 during reset.
- Rotation: `i_req`=4'b1111 held; each owner asserts `i_release` 2 cycles after its grant. Expect grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Wrap and skip: `ptr`=3 (after a grant to 2), then `i_req`=4'b0011. Expect the winner to be 0, then 1 on the next arbitration.
- Timeout: `MAX_HOLD`=4, `i_req`=4'b0001 held, no release. Expect `o_gnt_valid` high for exactly 4 cycles, `o_timeout` pulse on the following cycle, and a re-grant to 0 one cycle after that.
- Timeout collision: `i_release`=1 on the 4th grant cycle with `MAX_HOLD`=4. Expect `o_timeout`=0.
- Mid-grant reset: assert `i_rst_n`=0 while `o_gnt`=4'b0100. Expect all outputs 0 on the next edge; after release of reset with `i_req`=4'b1111, the next winner is 0.
